// File: rtl/spi_reg_target_pkg.sv
// Shared types and command-byte field positions for the SPI register target.
package spi_reg_target_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WR   = 2'd2,
        RD   = 2'd3
    } state_e;

    localparam int unsigned CmdRnwBit  = 7;
    localparam int unsigned CmdAddrMsb = 6;

endpackage

// File: rtl/spi_target_sync.sv
// Brings SCK/CSB/MOSI into the system clock domain and flags SCK/CSB edges.
// Edge strobes are single-cycle and line up with the synchronized MOSI sample.
module spi_target_sync (
    input  logic clk,
    input  logic rst,
    input  logic sck_in,
    input  logic csb_in,
    input  logic mosi_in,
    output logic sck_rise,
    output logic sck_fall,
    output logic csb_rise,
    output logic csb_fall,
    output logic mosi
);

    logic [2:0] sck_q;
    logic [2:0] csb_q;
    logic [1:0] mosi_q;

    // CSB resets to its idle-high level so reset release never looks like a select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q  <= 3'b000;
            csb_q  <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], sck_in};
            csb_q  <= {csb_q[1:0], csb_in};
            mosi_q <= {mosi_q[0], mosi_in};
        end
    end

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign csb_rise = csb_q[1] & ~csb_q[2];
    assign csb_fall = ~csb_q[1] & csb_q[2];
    assign mosi     = mosi_q[1];

endmodule

// File: rtl/spi_reg_target.sv
// SPI mode-0 target exposing a byte-wide register file: command byte then data stream.
// Write strobe follows the 8th SCK rise by 3 clocks; the host paces everything, no backpressure.
module spi_reg_target
    import spi_reg_target_pkg::*;
#(
    parameter int unsigned NumRegs = 16,
    parameter logic [7:0]  IdByte  = 8'hA5,
    localparam int unsigned AddrW  = $clog2(NumRegs)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   spi_sck_i,
    input  logic                   spi_csb_i,
    input  logic                   spi_mosi_i,
    output logic                   spi_miso_o,
    output logic                   spi_miso_en_o,
    output logic [NumRegs*8-1:0]   regs_o,
    output logic                   wr_pulse_o,
    output logic [AddrW-1:0]       wr_addr_o
);

    logic sck_rise;
    logic sck_fall;
    logic csb_rise;
    logic csb_fall;
    logic mosi;

    spi_target_sync u_sync (
        .clk      (clk_i),
        .rst      (rst_i),
        .sck_in   (spi_sck_i),
        .csb_in   (spi_csb_i),
        .mosi_in  (spi_mosi_i),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .csb_rise (csb_rise),
        .csb_fall (csb_fall),
        .mosi     (mosi)
    );

    state_e                  state;
    logic [2:0]              bit_cnt;
    logic [7:0]              rx_q;
    logic [7:0]              tx_q;
    logic [7:0]              rx_next;
    logic [AddrW-1:0]        ptr;
    logic [AddrW-1:0]        cmd_addr;
    logic [NumRegs-1:0][7:0] regs_q;

    assign rx_next    = {rx_q[6:0], mosi};
    assign cmd_addr   = AddrW'(rx_next[CmdAddrMsb:0]);
    assign spi_miso_o = tx_q[7];
    assign regs_o     = regs_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            rx_q          <= 8'h00;
            tx_q          <= 8'h00;
            ptr           <= '0;
            regs_q        <= '0;
            spi_miso_en_o <= 1'b0;
            wr_pulse_o    <= 1'b0;
            wr_addr_o     <= '0;
        end else begin
            wr_pulse_o <= 1'b0;
            if (csb_fall) begin
                state         <= CMD;
                bit_cnt       <= 3'd0;
                tx_q          <= IdByte;
                spi_miso_en_o <= 1'b1;
            end else if (state != IDLE) begin
                if (sck_rise) begin
                    rx_q    <= rx_next;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            CMD: begin
                                if (rx_next[CmdRnwBit]) begin
                                    state <= RD;
                                    tx_q  <= regs_q[cmd_addr];
                                    ptr   <= cmd_addr + AddrW'(1);
                                end else begin
                                    state <= WR;
                                    tx_q  <= 8'h00;
                                    ptr   <= cmd_addr;
                                end
                            end
                            WR: begin
                                regs_q[ptr] <= rx_next;
                                wr_pulse_o  <= 1'b1;
                                wr_addr_o   <= ptr;
                                ptr         <= ptr + AddrW'(1);
                            end
                            RD: begin
                                tx_q <= regs_q[ptr];
                                ptr  <= ptr + AddrW'(1);
                            end
                            default: ;
                        endcase
                    end
                end else if (sck_fall && bit_cnt != 3'd0) begin
                    // Hold the MSB of a freshly loaded byte until the next byte's first rise.
                    tx_q <= {tx_q[6:0], 1'b0};
                end
                // Placed after the byte logic so a coincident completion still commits.
                if (csb_rise) begin
                    state         <= IDLE;
                    bit_cnt       <= 3'd0;
                    tx_q          <= 8'h00;
                    spi_miso_en_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_target.sv
// Directed and randomized frames against a register-array model of the SPI target.
module tb_spi_reg_target;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sck = 1'b0;
    logic         csb = 1'b1;
    logic         mosi = 1'b0;
    logic         miso;
    logic         miso_en;
    logic [127:0] regs;
    logic         wr_pulse;
    logic [3:0]   wr_addr;

    spi_reg_target #(.NumRegs(16), .IdByte(8'hA5)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .spi_sck_i     (sck),
        .spi_csb_i     (csb),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .spi_miso_en_o (miso_en),
        .regs_o        (regs),
        .wr_pulse_o    (wr_pulse),
        .wr_addr_o     (wr_addr)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         passed = 0;
    logic [7:0] mregs [16];
    logic [7:0] fbytes [8];
    logic [7:0] fmiso [8];
    logic       fen;
    time        rise_t = 0;
    int         pulse_q [$];
    int         lat_q [$];
    int         exp_q [$];

    always @(negedge clk) begin
        if (wr_pulse === 1'b1) begin
            pulse_q.push_back(int'(wr_addr));
            lat_q.push_back(int'(($time - rise_t) / 10));
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] model_packed();
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = mregs[k];
        return v;
    endfunction

    // One frame: fbytes[0] is the command; the last byte carries last_bits bits.
    task automatic frame(input int n, input int last_bits, input bit close);
        int nb;
        csb = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < n; b++) begin
            nb = (b == n - 1) ? last_bits : 8;
            fmiso[b] = 8'h00;
            for (int i = 7; i >= 8 - nb; i--) begin
                mosi = fbytes[b][i];
                repeat (8) @(negedge clk);
                fmiso[b][i] = miso;
                sck = 1'b1;
                rise_t = $time;
                repeat (8) @(negedge clk);
                sck = 1'b0;
            end
            if (b == 0) fen = miso_en;
        end
        if (close) begin
            repeat (8) @(negedge clk);
            csb = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic check_pulses(input string tag);
        check({tag, "_npulse"}, 128'(pulse_q.size()), 128'(exp_q.size()));
        while (pulse_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_waddr"}, 128'(pulse_q.pop_front()), 128'(exp_q.pop_front()));
            check({tag, "_lat"}, 128'(lat_q.pop_front()), 128'd3);
        end
        pulse_q.delete();
        lat_q.delete();
        exp_q.delete();
    endtask

    // Full frame of n bytes, with MISO and register effects predicted from the model.
    task automatic run_frame(input string tag, input int n);
        bit rnw;
        int a;
        int r;
        rnw = fbytes[0][7];
        a = int'(fbytes[0]) % 16;
        frame(n, 8, 1'b1);
        check({tag, "_id"}, 128'(fmiso[0]), 128'hA5);
        check({tag, "_en"}, 128'(fen), 128'd1);
        for (int k = 1; k < n; k++) begin
            r = (a + k - 1) % 16;
            check({tag, "_miso"}, 128'(fmiso[k]), rnw ? 128'(mregs[r]) : 128'h0);
            if (!rnw) begin
                mregs[r] = fbytes[k];
                exp_q.push_back(r);
            end
        end
        check({tag, "_regs"}, regs, model_packed());
        check({tag, "_en_off"}, 128'(miso_en), 128'd0);
        check_pulses(tag);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mregs[k] = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_regs", regs, 128'h0);
        check("rst_en", 128'(miso_en), 128'd0);
        check("rst_miso", 128'(miso), 128'd0);
        check("rst_waddr", 128'(wr_addr), 128'd0);

        for (int i = 0; i < 20; i++) begin
            mosi = 1'($urandom);
            sck = ~sck;
            repeat (8) @(negedge clk);
        end
        sck = 1'b0;
        repeat (8) @(negedge clk);
        check("idle_regs", regs, 128'h0);
        check("idle_en", 128'(miso_en), 128'd0);
        check_pulses("idle");

        fbytes[0] = 8'h03; fbytes[1] = 8'hDE; fbytes[2] = 8'hAD;
        run_frame("wr3", 3);
        fbytes[0] = 8'h83; fbytes[1] = 8'h00; fbytes[2] = 8'h00;
        run_frame("rd3", 3);
        fbytes[0] = 8'h0F; fbytes[1] = 8'h11; fbytes[2] = 8'h22;
        run_frame("wrap", 3);
        fbytes[0] = 8'h8F;
        run_frame("rdwrap", 3);

        fbytes[0] = 8'h05; fbytes[1] = 8'h99;
        frame(2, 5, 1'b1);
        check("abort_regs", regs, model_packed());
        check("abort_en", 128'(miso_en), 128'd0);
        check("abort_miso", 128'(miso), 128'd0);
        check_pulses("abort");

        fbytes[0] = 8'h02; fbytes[1] = 8'h55; fbytes[2] = 8'h66;
        frame(3, 4, 1'b0);
        exp_q.push_back(2);
        rst = 1'b1;
        csb = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        for (int k = 0; k < 16; k++) mregs[k] = 8'h00;
        check("midrst_regs", regs, 128'h0);
        check("midrst_en", 128'(miso_en), 128'd0);
        check("midrst_waddr", 128'(wr_addr), 128'd0);
        check_pulses("midrst");
        fbytes[0] = 8'h01; fbytes[1] = 8'h77;
        run_frame("postrst", 2);

        for (int t = 0; t < 16; t++) begin
            int n;
            n = int'($urandom_range(2, 5));
            fbytes[0] = 8'($urandom_range(0, 255));
            for (int k = 1; k < n; k++) fbytes[k] = 8'($urandom_range(0, 255));
            run_frame("rand", n);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
